serial_add_ctrl: RTL

- Bit-serial addition controller: accepts a WIDTH-bit operand pair over a valid/ready handshake.
- Sequences the pair LSB-first through one full-adder bit cell with a registered carry, WIDTH cycles per operation.
- Returns the assembled sum and carry-out over a second valid/ready handshake.
- Sits between a requesting datapath and the combinational adder cells; trades area for latency.

---
 rtl/serial_add_ctrl.sv | 114 +++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell and a registered carry, WIDTH cycles per op.
// Optional subtract mode and signed-overflow flag are built when SERIAL_ADD_SUB_EN is defined.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, cout_q, out_valid_q;
  logic             bit_s, carry_d;
  logic [WIDTH-1:0] a_sh_d, b_ld;
  logic             c_ld;
`ifdef SERIAL_ADD_SUB_EN
  logic             ovf_q;
`endif

  // a_sh doubles as the sum shift register: sum bits fill the MSBs vacated by the operand.
  always_comb begin
    bit_s   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    carry_d = (a_sh_q[0] & b_sh_q[0]) | ((a_sh_q[0] ^ b_sh_q[0]) & carry_q);
    a_sh_d  = {bit_s, a_sh_q[WIDTH-1:1]};
`ifdef SERIAL_ADD_SUB_EN
    b_ld    = sub ? ~b : b;
    c_ld    = sub ? 1'b1 : cin;
`else
    b_ld    = b;
    c_ld    = cin;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_sh_q  <= a;
            b_sh_q  <= b_ld;
            carry_q <= c_ld;
            cnt_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh_q  <= a_sh_d;
          b_sh_q  <= b_sh_q >> 1;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            sum_q       <= a_sh_d;
            cout_q      <= carry_d;
            out_valid_q <= 1'b1;
            cnt_q       <= '0;
            state_q     <= S_DONE;
`ifdef SERIAL_ADD_SUB_EN
            // carry_q here is the carry into the MSB cell
            ovf_q       <= carry_q ^ carry_d;
`endif
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = rst_n && (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef SERIAL_ADD_SUB_EN
  assign ovf       = ovf_q;
`endif

endmodule
